// File: rtl/mips_defs_pkg.sv
// Shared constants and types for the MIPS front end.
package mips_defs;

  localparam logic [31:0] RESET_PC_DEF   = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

  // BOOT issues the reset-vector read; RUN is normal sequencing.
  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // Instruction addresses must be word aligned.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/if_fetch_stage_npc_mux.sv
// Next-PC priority select: boot, exception, ERET, stall, branch, sequential.
module npc_mux
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        i_boot,
  input  logic        i_exc_flush,
  input  logic        i_eret_flush,
  input  logic        i_en,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_epc,
  input  logic [31:0] i_pc,
  output logic [31:0] o_npc
);

  // Priority chain; flushes beat a stall, and a stalled branch is dropped
  // because ID holds it and will present it again.
  always_comb begin
    // NOTE: o_npc gets a default before any branch so no path can leave it
    // unassigned and infer a latch.
    o_npc = i_pc + 32'd4;
    if (i_boot)              o_npc = RESET_PC;
    else if (i_exc_flush)    o_npc = EXC_VECTOR;
    else if (i_eret_flush)   o_npc = i_epc;
    else if (!i_en)          o_npc = i_pc;
    else if (i_branch_taken) o_npc = i_branch_target;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns pc_F, drives the synchronous instruction
// SRAM with the next PC and produces the IF/ID payload.
module if_fetch_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        En,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Is_Branch_D,
  input  logic        Exc_Flush,
  input  logic        Eret_Flush,
  input  logic [31:0] EPC,
  input  logic [31:0] inst_sram_rdata,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  output logic [31:0] Instr_F,
  output logic [31:0] N_PC4_D,
  output logic [31:0] N_PC8_D,
  output logic [31:0] N_debug_pc_D,
  output logic        PC_EXC_IF,
  output logic        Delay_Next,
  output logic        flush_FD
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc_f;
  logic         r_fetch_valid;
  logic [31:0]  w_npc;
  logic         w_boot;
  logic         w_redirect;

  assign w_boot     = (r_state == ST_BOOT);
  assign w_redirect = Exc_Flush | Eret_Flush;

  npc_mux #(
    .RESET_PC   (RESET_PC),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_npc_mux (
    .i_boot          (w_boot),
    .i_exc_flush     (Exc_Flush),
    .i_eret_flush    (Eret_Flush),
    .i_en            (En),
    .i_branch_taken  (Branch_Taken),
    .i_branch_target (Branch_Target),
    .i_epc           (EPC),
    .i_pc            (r_pc_f),
    .o_npc           (w_npc)
  );

  // FSM next state: BOOT lasts exactly one cycle, RUN is terminal.
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_BOOT) w_state_next = ST_RUN;
  end

  // PC, state and fetch-valid registers; reset discards any in-flight read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_BOOT;
      r_pc_f        <= RESET_PC;
      r_fetch_valid <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_state       <= w_state_next;
      r_pc_f        <= w_npc;
      r_fetch_valid <= w_boot ? 1'b1 : !w_redirect;
    end
  end

  // SRAM request: address is the next PC; misaligned addresses issue no read.
  assign inst_sram_addr  = w_npc;
  assign inst_sram_en    = rst && is_word_aligned(w_npc);
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;

  // IF/ID payload for the instruction at pc_F.
  assign PC_EXC_IF    = !is_word_aligned(r_pc_f);
  assign Instr_F      = (r_fetch_valid && !PC_EXC_IF) ? inst_sram_rdata : NOP_INSTR;
  assign N_debug_pc_D = r_pc_f;
  assign N_PC4_D      = r_pc_f + 32'd4;
  assign N_PC8_D      = r_pc_f + 32'd8;
  assign flush_FD     = w_boot | w_redirect;
  assign Delay_Next   = Is_Branch_D && (r_state == ST_RUN) && !flush_FD;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed table, hand-written
// stall and async-reset sequences, then randomized traffic vs a PC model.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        En, Branch_Taken, Is_Branch_D, Exc_Flush, Eret_Flush;
  logic [31:0] Branch_Target, EPC;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [31:0] Instr_F, N_PC4_D, N_PC8_D, N_debug_pc_D;
  logic        PC_EXC_IF, Delay_Next, flush_FD;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .En              (En),
    .Branch_Taken    (Branch_Taken),
    .Branch_Target   (Branch_Target),
    .Is_Branch_D     (Is_Branch_D),
    .Exc_Flush       (Exc_Flush),
    .Eret_Flush      (Eret_Flush),
    .EPC             (EPC),
    .inst_sram_rdata (inst_sram_rdata),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .Instr_F         (Instr_F),
    .N_PC4_D         (N_PC4_D),
    .N_PC8_D         (N_PC8_D),
    .N_debug_pc_D    (N_debug_pc_D),
    .PC_EXC_IF       (PC_EXC_IF),
    .Delay_Next      (Delay_Next),
    .flush_FD        (flush_FD)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  // Synchronous-read SRAM with one cycle of latency.
  always @(posedge clk) if (inst_sram_en) inst_sram_rdata <= mem_f(inst_sram_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    En = 1'b1; Branch_Taken = 1'b0; Branch_Target = 32'h0; Is_Branch_D = 1'b0;
    Exc_Flush = 1'b0; Eret_Flush = 1'b0; EPC = 32'h0;
  endtask

  typedef struct {
    logic        en, bt, isb, exc, eret;
    logic [31:0] tgt, epc;
    logic [31:0] exp_pc, exp_addr;
    logic        exp_sen, exp_flush, exp_delay, exp_valid;
  } vec_t;

  vec_t vecs[11];

  // Reference model state.
  logic        m_boot, m_valid;
  logic [31:0] m_pc;

  initial begin
    logic [31:0] e_npc, e_instr, held;

    // en bt isb exc eret tgt epc | pc addr sram_en flush delay valid
    vecs[0]  = '{1,0,0,0,0, 32'h0,         32'h0,         32'hBFC00000, 32'hBFC00004, 1,0,0,1};
    vecs[1]  = '{1,0,0,0,0, 32'h0,         32'h0,         32'hBFC00004, 32'hBFC00008, 1,0,0,1};
    vecs[2]  = '{1,1,1,0,0, 32'hBFC00100,  32'h0,         32'hBFC00008, 32'hBFC00100, 1,0,1,1};
    vecs[3]  = '{0,1,0,0,0, 32'hBFC00200,  32'h0,         32'hBFC00100, 32'hBFC00100, 1,0,0,1};
    vecs[4]  = '{0,0,1,1,0, 32'h0,         32'h0,         32'hBFC00100, 32'hBFC00380, 1,1,0,1};
    vecs[5]  = '{1,0,0,1,1, 32'h0,         32'hBFC00040,  32'hBFC00380, 32'hBFC00380, 1,1,0,0};
    vecs[6]  = '{1,0,0,0,1, 32'h0,         32'hBFC00040,  32'hBFC00380, 32'hBFC00040, 1,1,0,0};
    vecs[7]  = '{1,1,0,0,0, 32'hBFC00102,  32'h0,         32'hBFC00040, 32'hBFC00102, 0,0,0,0};
    vecs[8]  = '{1,0,0,0,0, 32'h0,         32'h0,         32'hBFC00102, 32'hBFC00106, 0,0,0,1};
    vecs[9]  = '{1,1,0,0,0, 32'hFFFFFFFC,  32'h0,         32'hBFC00106, 32'hFFFFFFFC, 1,0,0,1};
    vecs[10] = '{1,0,0,0,0, 32'h0,         32'h0,         32'hFFFFFFFC, 32'h00000000, 1,0,0,1};

    // Reset held: quiet SRAM, bubble, NOP, no delay slot.
    rst = 1'b0;
    idle();
    Is_Branch_D = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_sram_en", 32'(inst_sram_en), 32'd0);
    check("rst_flush",   32'(flush_FD),     32'd1);
    check("rst_instr",   Instr_F,           32'h0);
    check("rst_delay",   32'(Delay_Next),   32'd0);
    check("rst_exc_if",  32'(PC_EXC_IF),    32'd0);
    check("rst_wen",     32'(inst_sram_wen), 32'd0);

    // Release: BOOT cycle reads the reset vector with a bubble.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("boot_addr",    inst_sram_addr,    RST_PC);
    check("boot_flush",   32'(flush_FD),     32'd1);
    check("boot_sram_en", 32'(inst_sram_en), 32'd1);
    check("boot_delay",   32'(Delay_Next),   32'd0);

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      En = vecs[i].en; Branch_Taken = vecs[i].bt; Is_Branch_D = vecs[i].isb;
      Exc_Flush = vecs[i].exc; Eret_Flush = vecs[i].eret;
      Branch_Target = vecs[i].tgt; EPC = vecs[i].epc;
      #1;
      e_instr = (vecs[i].exp_valid && vecs[i].exp_pc[1:0] == 2'b00) ? mem_f(vecs[i].exp_pc) : 32'h0;
      check($sformatf("vec%0d_pc", i),      N_debug_pc_D,       vecs[i].exp_pc);
      check($sformatf("vec%0d_pc4", i),     N_PC4_D,            vecs[i].exp_pc + 32'd4);
      check($sformatf("vec%0d_pc8", i),     N_PC8_D,            vecs[i].exp_pc + 32'd8);
      check($sformatf("vec%0d_addr", i),    inst_sram_addr,     vecs[i].exp_addr);
      check($sformatf("vec%0d_sram_en", i), 32'(inst_sram_en),  32'(vecs[i].exp_sen));
      check($sformatf("vec%0d_flush", i),   32'(flush_FD),      32'(vecs[i].exp_flush));
      check($sformatf("vec%0d_delay", i),   32'(Delay_Next),    32'(vecs[i].exp_delay));
      check($sformatf("vec%0d_exc_if", i),  32'(PC_EXC_IF),     32'(vecs[i].exp_pc[1:0] != 2'b00));
      check($sformatf("vec%0d_instr", i),   Instr_F,            e_instr);
    end

    // Stall sequence at BFC00010: address and instruction held for 3 cycles.
    @(negedge clk);
    idle(); Branch_Taken = 1'b1; Branch_Target = 32'hBFC0_0010;
    #1;
    check("stall_pre_pc", N_debug_pc_D, 32'h0);
    @(negedge clk);
    idle(); En = 1'b0;
    #1;
    held = Instr_F;
    check("stall_instr_first", held, mem_f(32'hBFC0_0010));
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("stall%0d_addr", k),  inst_sram_addr, 32'hBFC0_0010);
      check($sformatf("stall%0d_pc", k),    N_debug_pc_D,   32'hBFC0_0010);
      check($sformatf("stall%0d_instr", k), Instr_F,        held);
    end
    @(negedge clk);
    idle();
    #1;
    check("unstall_addr",  inst_sram_addr, 32'hBFC0_0014);
    check("unstall_instr", Instr_F,        mem_f(32'hBFC0_0010));

    // Async reset between edges at pc_F=BFC00200.
    @(negedge clk);
    idle(); Branch_Taken = 1'b1; Branch_Target = 32'hBFC0_0200;
    @(negedge clk);
    idle();
    #1;
    check("arst_pre_pc", N_debug_pc_D, 32'hBFC0_0200);
    #2;
    rst = 1'b0;
    #1;
    check("arst_pc",      N_debug_pc_D,      RST_PC);
    check("arst_sram_en", 32'(inst_sram_en), 32'd0);
    check("arst_flush",   32'(flush_FD),     32'd1);
    check("arst_instr",   Instr_F,           32'h0);

    // Release straight into randomized traffic; the model starts in BOOT.
    @(negedge clk);
    rst = 1'b1;
    m_boot = 1'b1; m_valid = 1'b0; m_pc = RST_PC;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) @(negedge clk);
      En            = ($urandom_range(0, 3) != 0);
      Branch_Taken  = ($urandom_range(0, 2) == 0);
      Is_Branch_D   = ($urandom_range(0, 1) == 0);
      Exc_Flush     = ($urandom_range(0, 19) == 0);
      Eret_Flush    = ($urandom_range(0, 19) == 0);
      Branch_Target = {16'hBFC0, 16'($urandom) & 16'hFFFC};
      if ($urandom_range(0, 15) == 0) Branch_Target[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) Branch_Target = 32'hFFFF_FFFC;
      EPC           = {16'hBFC0, 16'($urandom) & 16'hFFFC};
      #1;
      // Spec-level next-PC choice.
      if (m_boot)            e_npc = RST_PC;
      else if (Exc_Flush)    e_npc = EXC_PC;
      else if (Eret_Flush)   e_npc = EPC;
      else if (!En)          e_npc = m_pc;
      else if (Branch_Taken) e_npc = Branch_Target;
      else                   e_npc = m_pc + 32'd4;
      e_instr = (m_valid && m_pc[1:0] == 2'b00) ? mem_f(m_pc) : 32'h0;
      check("rnd_addr",    inst_sram_addr,    e_npc);
      check("rnd_sram_en", 32'(inst_sram_en), 32'(e_npc[1:0] == 2'b00));
      check("rnd_flush",   32'(flush_FD),     32'(m_boot | Exc_Flush | Eret_Flush));
      check("rnd_delay",   32'(Delay_Next),   32'(Is_Branch_D && !m_boot && !Exc_Flush && !Eret_Flush));
      check("rnd_pc",      N_debug_pc_D,      m_pc);
      check("rnd_pc4",     N_PC4_D,           m_pc + 32'd4);
      check("rnd_pc8",     N_PC8_D,           m_pc + 32'd8);
      check("rnd_exc_if",  32'(PC_EXC_IF),    32'(m_pc[1:0] != 2'b00));
      check("rnd_instr",   Instr_F,           e_instr);
      m_valid = m_boot ? 1'b1 : !(Exc_Flush || Eret_Flush);
      m_pc    = e_npc;
      m_boot  = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
